// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives imem address,
// and hands fetched words to decode through a valid/ready IR.
module fetch_sequencer #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);

  state_t      state;
  logic [15:0] pc;
  logic        xfer;
  logic        load;
  logic        oob;
  logic        is_halt;
  logic        do_redir;
  logic        do_stall;
  logic        do_load;
  logic        do_hold;

  assign imem_addr = pc;
  assign busy      = (state == RUN);
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);

  assign xfer    = ir_valid & ir_ready;
  assign load    = !ir_valid | ir_ready;
  assign oob     = ({1'b0, pc} >= DEPTH);
  assign is_halt = (imem_rdata == HALT_INSTR);

  // One-hot RUN actions, highest priority first
  assign do_redir = redirect_valid;
  assign do_stall = !redirect_valid & stall;
  assign do_load  = !redirect_valid & !stall & load;
  assign do_hold  = !redirect_valid & !stall & !load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= 16'h0000;
      ir_pc       <= 16'h0000;
      ir_valid    <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      if (xfer && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= RESET_PC;
          end
        end
        RUN: begin
          unique case (1'b1)
            do_redir: begin
              pc       <= redirect_addr;
              ir_valid <= 1'b0;
            end
            do_stall: begin
              if (xfer)
                ir_valid <= 1'b0;
            end
            do_load: begin
              if (oob) begin
                state    <= FAULT;
                ir_valid <= 1'b0;
              end else if (is_halt) begin
                state    <= HALT;
                ir_valid <= 1'b0;
              end else begin
                ir       <= imem_rdata;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + 16'd1;
              end
            end
            do_hold: begin
              ir_valid <= ir_valid;
            end
            default: begin
              ir_valid <= ir_valid;
            end
          endcase
        end
        HALT: begin
          ir_valid <= 1'b0;
          if (start) begin
            state <= RUN;
            pc    <= RESET_PC;
          end
        end
        FAULT: begin
          ir_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
